psum_accumulator: RTL and testbench

//  Downstream of the 3-row PE array. Per transfer it sums the three 25-bit row partial sums
//  (one PE per kernel row) into a 3x3 window result and accumulates across input channels.
//  On the last channel it adds bias, applies ReLU, rounds, shifts and saturates to an

---
 rtl/psum_accumulator.sv | 154 +++++++++++++++
 tb/tb_psum_accumulator.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Sums three kernel-row partial sums per beat, accumulates across input channels and,
// on the last channel, applies bias, ReLU and rounding requantisation to an 8-bit activation.
module psum_accumulator #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned SHIFT = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [24:0]      psum0,
    input  logic signed [24:0]      psum1,
    input  logic signed [24:0]      psum2,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] bias,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        ch_count,
    output logic                    err
);

    localparam int unsigned ROW_W = 27;
    localparam int unsigned OUT_W = 8;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic [ACC_W:0]          RND     = (ACC_W+1)'(1) << (SHIFT-1);
    localparam logic [ACC_W:0]          OUT_MAX = (ACC_W+1)'(255);

    // Signed add that clamps to the accumulator range instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0]   s;
        logic signed [ACC_W-1:0] r;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        if (s[ACC_W] != s[ACC_W-1]) begin
            r = s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            r = s[ACC_W-1:0];
        end
        return r;
    endfunction

    logic                    stall;
    logic                    xfer;
    logic signed [ROW_W-1:0] row_sum_c;

    logic                    s1_valid;
    logic                    s1_first;
    logic                    s1_last;
    logic signed [ROW_W-1:0] s1_sum;

    logic                    s2_valid;
    logic                    s2_last;
    logic signed [ACC_W-1:0] acc;
    logic                    acc_active;

    logic signed [ACC_W-1:0] row_ext_c;
    logic signed [ACC_W-1:0] acc_sum_c;
    logic                    restart_c;
    logic [CNT_W-1:0]        cnt_inc_c;

    logic signed [ACC_W-1:0] biased_c;
    logic [ACC_W-1:0]        relu_c;
    logic [ACC_W:0]          rounded_c;
    logic [ACC_W:0]          shifted_c;
    logic [OUT_W-1:0]        act_c;

    // A held output freezes the whole pipeline.
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign xfer      = in_valid & in_ready;
    assign row_sum_c = ROW_W'(psum0) + ROW_W'(psum1) + ROW_W'(psum2);

    // S1: window row sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
        end else if (!stall) begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_first <= in_first;
                s1_last  <= in_last;
                s1_sum   <= row_sum_c;
            end
        end
    end

    // A beat with no open window is treated as a window start.
    always_comb begin
        row_ext_c = ACC_W'(s1_sum);
        acc_sum_c = sat_add(acc, row_ext_c);
        restart_c = s1_first | ~acc_active;
        cnt_inc_c = (ch_count == {CNT_W{1'b1}}) ? ch_count : ch_count + CNT_W'(1);
    end

    // S2: channel accumulation and framing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            acc        <= '0;
            acc_active <= 1'b0;
            ch_count   <= '0;
            err        <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                if (restart_c) begin
                    acc      <= row_ext_c;
                    ch_count <= CNT_W'(1);
                end else begin
                    acc      <= acc_sum_c;
                    ch_count <= cnt_inc_c;
                end
                if (s1_first == acc_active) begin
                    err <= 1'b1;
                end
                acc_active <= ~s1_last;
            end
        end
    end

    // Bias, ReLU, round-half-up shift, clamp to 8 bits.
    always_comb begin
        biased_c  = sat_add(acc, bias);
        relu_c    = biased_c[ACC_W-1] ? '0 : biased_c;
        rounded_c = {1'b0, relu_c} + RND;
        shifted_c = rounded_c >> SHIFT;
        act_c     = (shifted_c > OUT_MAX) ? 8'hFF : shifted_c[OUT_W-1:0];
    end

    // S3: output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            out_valid <= s2_valid & s2_last;
            if (s2_valid && s2_last) begin
                out_data <= act_c;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: directed vectors, corner sequences and
// randomized traffic against a behavioural window model.
module tb_psum_accumulator;

    localparam int unsigned ACC_W = 32;
    localparam int unsigned SHIFT = 8;
    localparam int unsigned CNT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [24:0]      psum0, psum1, psum2;
    logic                    in_first, in_last, in_valid, in_ready;
    logic signed [ACC_W-1:0] bias;
    logic [7:0]              out_data;
    logic                    out_valid, out_ready;
    logic [CNT_W-1:0]        ch_count;
    logic                    err;

    logic                    in_ready27;
    logic [7:0]              out_data27;
    logic                    out_valid27;
    logic [CNT_W-1:0]        ch_count27;
    logic                    err27;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    longint m_acc;
    bit     m_active;
    int     m_cnt;
    bit     m_err;
    int     exp_q[$];

    typedef struct {
        logic signed [24:0] p0;
        logic signed [24:0] p1;
        logic signed [24:0] p2;
        logic signed [31:0] b;
        int                 exp_out;
    } vec_t;
    vec_t vecs[8];

    psum_accumulator #(.ACC_W(ACC_W), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .psum0(psum0), .psum1(psum1), .psum2(psum2),
        .in_first(in_first), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .bias(bias), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ch_count(ch_count), .err(err)
    );

    psum_accumulator #(.ACC_W(27), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut27 (
        .clk(clk), .rst(rst), .psum0(psum0), .psum1(psum1), .psum2(psum2),
        .in_first(in_first), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready27),
        .bias(bias[26:0]), .out_data(out_data27), .out_valid(out_valid27), .out_ready(out_ready),
        .ch_count(ch_count27), .err(err27)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the block accepts it.
    task automatic send(input logic signed [24:0] a, input logic signed [24:0] b,
                        input logic signed [24:0] c, input logic f, input logic l);
        bit ok;
        psum0 = a; psum1 = b; psum2 = c;
        in_first = f; in_last = l; in_valid = 1'b1;
        ok = 1'b0;
        #1;
        for (int k = 0; k < 64 && !ok; k++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic collect(input int n, output int pulses, output int data,
                           output int pulses27, output int data27);
        pulses = 0; data = -1; pulses27 = 0; data27 = -1;
        for (int k = 0; k < n; k++) begin
            if (out_valid)   begin pulses++;   data   = out_data;   end
            if (out_valid27) begin pulses27++; data27 = out_data27; end
            tick();
        end
    endtask

    function automatic longint clampw(input longint v, input int w);
        longint hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int activation(input longint a, input longint b, input int w);
        longint v;
        v = clampw(a + b, w);
        if (v < 0) v = 0;
        v = (v + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        if (v > 255) v = 255;
        return int'(v);
    endfunction

    function automatic void m_reset();
        m_acc = 0; m_active = 1'b0; m_cnt = 0; m_err = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_beat(input logic signed [24:0] a, input logic signed [24:0] b,
                                       input logic signed [24:0] c, input bit f, input bit l,
                                       input logic signed [31:0] bs);
        longint rs;
        rs = longint'(a) + longint'(b) + longint'(c);
        if (f && m_active)  m_err = 1'b1;
        if (!f && !m_active) m_err = 1'b1;
        if (f || !m_active) begin
            m_acc = rs;
            m_cnt = 1;
        end else begin
            m_acc = clampw(m_acc + rs, ACC_W);
            if (m_cnt < 65535) m_cnt++;
        end
        m_active = !l;
        if (l) exp_q.push_back(activation(m_acc, longint'(bs), ACC_W));
    endfunction

    function automatic logic signed [24:0] rnd_psum();
        int t;
        if ($urandom_range(0, 1) == 0) return 25'($urandom);
        t = int'($urandom_range(0, 8000)) - 4000;
        return 25'(t);
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("in_ready_vs_stall", longint'(in_ready), longint'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
                else chk("rand_out_data", longint'(out_data), longint'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int pl, dt, pl27, dt27;
        bit fire;
        logic signed [24:0] c0, c1, c2;
        bit cf, cl;

        vecs[0] = '{25'sd100,       25'sd200,       25'sd300,       32'sd0,       2};
        vecs[1] = '{25'sd127,       25'sd0,         25'sd0,         32'sd0,       0};
        vecs[2] = '{25'sd128,       25'sd0,         25'sd0,         32'sd0,       1};
        vecs[3] = '{-25'sd1000,     25'sd0,         25'sd0,         32'sd5000,    16};
        vecs[4] = '{25'sd0,         25'sd0,         25'sd0,         32'sd65151,   254};
        vecs[5] = '{25'sd0,         25'sd0,         25'sd0,         32'sd65408,   255};
        vecs[6] = '{25'sd100,       25'sd0,         25'sd0,         -32'sd200,    0};
        vecs[7] = '{-25'sd16777216, -25'sd16777216, -25'sd16777216, 32'sd1000000, 0};

        rst = 1'b1; psum0 = '0; psum1 = '0; psum2 = '0;
        in_first = 1'b0; in_last = 1'b0; in_valid = 1'b0;
        bias = '0; out_ready = 1'b1;
        #12;
        chk("reset_in_ready",  longint'(in_ready),  1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data",  longint'(out_data),  0);
        chk("reset_ch_count",  longint'(ch_count),  0);
        chk("reset_err",       longint'(err),       0);
        tick();
        rst = 1'b0;
        tick();

        // Single-channel windows with exact latency.
        for (int i = 0; i < 8; i++) begin
            bias = vecs[i].b;
            send(vecs[i].p0, vecs[i].p1, vecs[i].p2, 1'b1, 1'b1);
            tick();
            chk("vec_early_valid", longint'(out_valid), 0);
            tick();
            chk("vec_valid",    longint'(out_valid), 1);
            chk("vec_out_data", longint'(out_data),  longint'(vecs[i].exp_out));
            chk("vec_ch_count", longint'(ch_count),  1);
            tick();
            chk("vec_valid_clear", longint'(out_valid), 0);
        end

        bias = 32'sd256;
        send(25'sd1000, 25'sd1000, 25'sd1000, 1'b1, 1'b0);
        send(25'sd1000, 25'sd1000, 25'sd1000, 1'b0, 1'b0);
        send(25'sd1000, 25'sd1000, 25'sd1000, 1'b0, 1'b0);
        send(25'sd1000, 25'sd1000, 25'sd1000, 1'b0, 1'b1);
        collect(6, pl, dt, pl27, dt27);
        chk("four_ch_pulses", pl, 1);
        chk("four_ch_data",   dt, 48);
        chk("four_ch_count",  longint'(ch_count), 4);

        bias = 32'sd100;
        send(-25'sd5000, 25'sd0, 25'sd0, 1'b1, 1'b0);
        send(-25'sd5000, 25'sd0, 25'sd0, 1'b0, 1'b1);
        collect(6, pl, dt, pl27, dt27);
        chk("relu_pulses", pl, 1);
        chk("relu_data",   dt, 0);
        chk("relu_count",  longint'(ch_count), 2);

        bias = 32'sd0;
        for (int i = 0; i < 3; i++)
            send(25'sd8388607, 25'sd8388607, 25'sd8388607, i == 0, i == 2);
        collect(6, pl, dt, pl27, dt27);
        chk("sat_pulses",    pl,   1);
        chk("sat_data",      dt,   255);
        chk("sat27_pulses",  pl27, 1);
        chk("sat27_data",    dt27, 255);

        // Backpressure: results wait in place and drain in order.
        out_ready = 1'b0;
        send(25'sd256, 25'sd0, 25'sd0, 1'b1, 1'b1);
        send(25'sd512, 25'sd0, 25'sd0, 1'b1, 1'b1);
        send(25'sd768, 25'sd0, 25'sd0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready",  longint'(in_ready),  0);
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_out_data",  longint'(out_data),  1);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("drain_valid", longint'(out_valid), 1);
            chk("drain_data",  longint'(out_data),  longint'(k + 1));
            tick();
        end
        chk("drain_done", longint'(out_valid), 0);
        chk("err_clean",  longint'(err),       0);

        // Framing: second first beat restarts the window.
        send(25'sd10000, 25'sd0, 25'sd0, 1'b1, 1'b0);
        send(25'sd512,   25'sd0, 25'sd0, 1'b1, 1'b0);
        send(25'sd256,   25'sd0, 25'sd0, 1'b0, 1'b1);
        collect(6, pl, dt, pl27, dt27);
        chk("restart_pulses", pl, 1);
        chk("restart_data",   dt, 3);
        chk("restart_count",  longint'(ch_count), 2);
        chk("restart_err",    longint'(err), 1);

        // Reset while a result is stalled.
        out_ready = 1'b0;
        send(25'sd512, 25'sd0, 25'sd0, 1'b1, 1'b1);
        tick();
        tick();
        chk("pre_rst_valid", longint'(out_valid), 1);
        chk("pre_rst_err",   longint'(err), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid",    longint'(out_valid), 0);
        chk("async_rst_err",      longint'(err), 0);
        chk("async_rst_in_ready", longint'(in_ready), 1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        collect(6, pl, dt, pl27, dt27);
        chk("post_rst_no_output", pl, 0);

        // Non-first beat with no open window.
        send(25'sd512, 25'sd0, 25'sd0, 1'b0, 1'b1);
        collect(6, pl, dt, pl27, dt27);
        chk("orphan_pulses", pl, 1);
        chk("orphan_data",   dt, 2);
        chk("orphan_count",  longint'(ch_count), 1);
        chk("orphan_err",    longint'(err), 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        m_reset();
        mon_en = 1'b1;

        for (int ph = 0; ph < 4; ph++) begin
            bias = (ph % 2 == 0) ? 32'(int'($urandom_range(0, 100000)) - 50000) : 32'($urandom);
            for (int c = 0; c < 400; c++) begin
                in_valid  = ($urandom_range(0, 4) != 0);
                in_first  = ($urandom_range(0, 3) == 0);
                in_last   = ($urandom_range(0, 3) == 0);
                psum0 = rnd_psum(); psum1 = rnd_psum(); psum2 = rnd_psum();
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                fire = in_valid && in_ready;
                c0 = psum0; c1 = psum1; c2 = psum2; cf = in_first; cl = in_last;
                tick();
                if (fire) model_beat(c0, c1, c2, cf, cl, bias);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
            chk("rand_drain_empty", longint'(exp_q.size()), 0);
            tick();
            tick();
        end
        mon_en = 1'b0;
        chk("rand_err",        longint'(err),        longint'(m_err));
        chk("rand_ch_count",   longint'(ch_count),   longint'(m_cnt));
        chk("rand_out_idle",   longint'(out_valid),  0);
        chk("dut27_err",       longint'(err27),      longint'(m_err));
        chk("dut27_ch_count",  longint'(ch_count27), longint'(m_cnt));
        chk("dut27_in_ready",  longint'(in_ready27), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
